// File: rtl/nn_pkg.sv
// Shared dimensions, widths and state type for the MLP layer scheduler.
package nn_pkg;

   localparam int NN_IN    = 784;
   localparam int NN_HID   = 64;
   localparam int NN_OUT   = 10;
   localparam int NN_ACC_W = 32;

   localparam int NN_W_AW = $clog2(NN_IN * NN_HID + NN_HID * NN_OUT);
   localparam int NN_B_AW = $clog2(NN_HID + NN_OUT);
   localparam int NN_A_AW = $clog2(NN_IN);
   localparam int NN_H_AW = $clog2(NN_HID);

   localparam int NN_W_BASE_OUT = NN_IN * NN_HID;
   localparam int NN_B_BASE_OUT = NN_HID;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACC,
      S_DRAIN,
      S_BIAS,
      S_WB,
      S_DONE
   } nn_sched_state_t;

   // address width that stays legal for tiny test configurations
   function automatic int nn_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int nn_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/nn_argmax.sv
// Running argmax over the output-layer post-bias results.
module nn_argmax
   import nn_pkg::*;
#(
   parameter int ACC_WIDTH = NN_ACC_W
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_en,
   input  logic                        i_first,
   input  logic signed [ACC_WIDTH-1:0] i_val,
   input  logic [3:0]                  i_idx,
   output logic [3:0]                  o_class_idx
);

   logic signed [ACC_WIDTH-1:0] r_best;
   logic [3:0]                  r_idx;

   // strict greater-than keeps the lower index on ties
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_best <= '0;
         r_idx  <= '0;
      end else if (i_en && (i_first || i_val > r_best)) begin
         r_best <= i_val;
         r_idx  <= i_idx;
      end
   end

   assign o_class_idx = r_idx;

endmodule

// File: rtl/nn_layer_scheduler.sv
// Neuron-by-neuron sequencer for the shared MAC/bias/ReLU datapath,
// walking the hidden layer then the output layer with argmax tracking.
module nn_layer_scheduler
   import nn_pkg::*;
#(
   parameter int INPUT_NEURONS  = NN_IN,
   parameter int HIDDEN_NEURONS = NN_HID,
   parameter int OUTPUT_NEURONS = NN_OUT,
   parameter int ACC_WIDTH      = NN_ACC_W,
   localparam int WW = nn_w(INPUT_NEURONS * HIDDEN_NEURONS
                            + HIDDEN_NEURONS * OUTPUT_NEURONS),
   localparam int BW = nn_w(HIDDEN_NEURONS + OUTPUT_NEURONS),
   localparam int AW = nn_w(INPUT_NEURONS),
   localparam int HW = nn_w(HIDDEN_NEURONS)
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_start,
   input  logic signed [ACC_WIDTH-1:0] i_acc_in,
   output logic [WW-1:0]               o_w_addr,
   output logic [BW-1:0]               o_b_addr,
   output logic [AW-1:0]               o_act_rd_addr,
   output logic                        o_act_rd_sel,
   output logic [HW-1:0]               o_act_wr_addr,
   output logic                        o_act_wr_en,
   output logic                        o_mac_clr,
   output logic                        o_mac_en,
   output logic                        o_bias_en,
   output logic                        o_relu_en,
   output logic                        o_busy,
   output logic                        o_done,
   output logic [3:0]                  o_class_idx,
   output logic                        o_class_valid
);

   localparam int NW = nn_max(HW, nn_w(OUTPUT_NEURONS));
   localparam int IW = nn_max(AW, HW);

   nn_sched_state_t r_state;
   logic            r_layer;
   logic [NW-1:0]   r_neuron;
   logic [IW-1:0]   r_input;
   logic [WW-1:0]   r_w_addr;
   logic [BW-1:0]   r_b_addr;
   logic            r_mac_clr;
   logic            r_mac_en;
   logic            r_bias_en;
   logic            r_act_wr_en;
   logic            r_relu_en;
   logic            r_busy;
   logic            r_done;
   logic            r_class_valid;

   logic [IW-1:0]   w_last_in;
   logic [NW-1:0]   w_last_n;
   logic            w_sample;

   assign w_last_in = r_layer ? IW'(HIDDEN_NEURONS - 1)
                              : IW'(INPUT_NEURONS - 1);
   assign w_last_n  = r_layer ? NW'(OUTPUT_NEURONS - 1)
                              : NW'(HIDDEN_NEURONS - 1);
   assign w_sample  = (r_state == S_WB) && r_layer;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_layer       <= 1'b0;
         r_neuron      <= '0;
         r_input       <= '0;
         r_w_addr      <= '0;
         r_b_addr      <= '0;
         r_mac_clr     <= 1'b0;
         r_mac_en      <= 1'b0;
         r_bias_en     <= 1'b0;
         r_act_wr_en   <= 1'b0;
         r_relu_en     <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_class_valid <= 1'b0;
      end else begin
         r_mac_clr   <= 1'b0;
         r_bias_en   <= 1'b0;
         r_act_wr_en <= 1'b0;
         r_relu_en   <= 1'b0;
         // MAC data returns one cycle after each address issue
         r_mac_en    <= (r_state == S_ACC);
         unique case (r_state)
            S_IDLE, S_DONE: begin
               // done waits one cycle so class_idx has settled
               if (r_state == S_DONE) begin
                  r_done        <= 1'b1;
                  r_class_valid <= 1'b1;
               end
               if (i_start) begin
                  r_state       <= S_ACC;
                  r_layer       <= 1'b0;
                  r_neuron      <= '0;
                  r_input       <= '0;
                  r_w_addr      <= '0;
                  r_mac_clr     <= 1'b1;
                  r_busy        <= 1'b1;
                  r_done        <= 1'b0;
                  r_class_valid <= 1'b0;
               end
            end
            S_ACC: begin
               if (r_input == w_last_in) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_input  <= r_input + 1'b1;
                  r_w_addr <= r_w_addr + 1'b1;
               end
            end
            S_DRAIN: begin
               r_state   <= S_BIAS;
               r_bias_en <= 1'b1;
               r_b_addr  <= r_layer ? BW'(HIDDEN_NEURONS) + BW'(r_neuron)
                                    : BW'(r_neuron);
            end
            S_BIAS: begin
               r_state     <= S_WB;
               r_act_wr_en <= ~r_layer;
               r_relu_en   <= ~r_layer;
            end
            S_WB: begin
               if (r_layer && r_neuron == w_last_n) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
               end else begin
                  // weights of consecutive neurons and layers are contiguous
                  r_state   <= S_ACC;
                  r_input   <= '0;
                  r_w_addr  <= r_w_addr + 1'b1;
                  r_mac_clr <= 1'b1;
                  if (r_neuron == w_last_n) begin
                     r_layer  <= 1'b1;
                     r_neuron <= '0;
                  end else begin
                     r_neuron <= r_neuron + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   nn_argmax #(
      .ACC_WIDTH(ACC_WIDTH)
   ) u_argmax (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (w_sample),
      .i_first    (r_neuron == '0),
      .i_val      (i_acc_in),
      .i_idx      (4'(r_neuron)),
      .o_class_idx(o_class_idx)
   );

   assign o_w_addr      = r_w_addr;
   assign o_b_addr      = r_b_addr;
   assign o_act_rd_addr = r_input[AW-1:0];
   assign o_act_rd_sel  = r_layer;
   assign o_act_wr_addr = r_neuron[HW-1:0];
   assign o_act_wr_en   = r_act_wr_en;
   assign o_mac_clr     = r_mac_clr;
   assign o_mac_en      = r_mac_en;
   assign o_bias_en     = r_bias_en;
   assign o_relu_en     = r_relu_en;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_class_valid = r_class_valid;

endmodule

// File: doc/nn_layer_scheduler.md
# nn_layer_scheduler

Sequencer for the time-multiplexed MLP datapath (784-64-10, Q5.11 weights, 32-bit bias). On `start`, it walks the hidden layer and then the output layer neuron by neuron, issuing weight, bias and activation addresses and MAC control strobes to the shared MAC/bias/ReLU datapath. During the output layer it tracks the argmax of the post-bias results and presents the class index to the 7-segment driver. It sits between the top-level `start`/`done` pins and the weight/bias/activation memories.

## Interface
- `INPUT_NEURONS`, 784, fan-in of the hidden layer
- `HIDDEN_NEURONS`, 64, hidden-layer size; also the fan-in of the output layer
- `OUTPUT_NEURONS`, 10, output-layer size (at most 16)
- `ACC_WIDTH`, 32, width of the datapath post-bias result `acc_in`
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin inference; sampled only in IDLE or DONE
- `acc_in`  in  ACC_WIDTH  signed post-bias result, valid in the WB cycle
- `w_addr`  out  clog2(IN·HID+HID·OUT)  weight memory address (1-cycle synchronous read)
- `b_addr`  out  clog2(HID+OUT)  bias memory address
- `act_rd_addr`  out  clog2(IN)  activation read address
- `act_rd_sel`  out  1  0 = input buffer, 1 = hidden buffer
- `act_wr_addr`  out  clog2(HID)  hidden-buffer write address
- `act_wr_en`  out  1  write the ReLU result into the hidden buffer
- `mac_clr`  out  1  clear the accumulator
- `mac_en`  out  1  accumulate weight × activation
- `bias_en`  out  1  add the bias to the accumulator
- `relu_en`  out  1  apply ReLU (hidden layer only)
- `busy`  out  1  inference in progress
- `done`  out  1  level; inference finished
- `class_idx`  out  4  argmax of the output layer
- `class_valid`  out  1  `class_idx` is valid

## Operation
- **States:** IDLE, ACC, DRAIN, BIAS, WB, DONE.
- **IDLE / DONE → ACC:** on `start`. Set layer=0, neuron=0, input=0. `done` and `class_valid` clear on that edge.
- **ACC:** one address issue per cycle for `input` = 0..fan_in−1.
  - Hidden layer: fan_in = IN, `w_addr` = n·IN + i, `act_rd_sel` = 0.
  - Output layer: fan_in = HID, `w_addr` = IN·HID + n·HID + i, `act_rd_sel` = 1.
  - `act_rd_addr` = i.
  - `mac_clr` is high in the first ACC cycle of each neuron.
  - On the last input, go to DRAIN.
- **DRAIN:** one cycle for the memory read latency. No address issue.
- **BIAS:** `b_addr` = n (hidden layer) or HID + n (output layer). `bias_en` = 1.
- **WB:**
  - Hidden layer: `act_wr_en` = 1, `act_wr_addr` = n, `relu_en` = 1.
  - Output layer: argmax update only. Neuron 0 initializes best = `acc_in`, idx = 0. A later neuron replaces best only if `acc_in` > best (signed). On a tie the lower index is kept.
  - Then go to the next neuron. After neuron HID−1, switch to the output layer. After neuron OUT−1, go to DONE.
- **DONE:** `done` = 1 and `class_valid` = 1. `class_idx` is held until the next `start`.
- `start` is ignored while `busy`.
- `busy` = 1 in ACC, DRAIN, BIAS and WB.

## Timing
- `mac_en` is `mac_clr`-aligned ACC issue delayed one cycle: high for exactly fan_in cycles per neuron, aligned with the returned memory data. The last `mac_en` falls in DRAIN.
- Cycles per neuron = fan_in + 3.
- Total latency, from the `start`-sampling edge to `done` high, = 1 + HID·(IN+3) + OUT·(HID+3). With default parameters this is 51039 cycles.
- `bias_en` is high one cycle after the last `mac_en`. `act_wr_en` and the argmax sample are one cycle after `bias_en`.
- **Reset values:** state IDLE; all addresses 0; all strobes 0; `busy`, `done` and `class_valid` 0; `class_idx` 0.
- **Reset mid-inference:** on the next edge the block is in IDLE with reset values. No further memory writes occur.
- **`start` and `rst` in the same cycle:** reset wins.

## Structure
- `nn_pkg` holds:
  - the default layer dimensions;
  - the derived address widths, computed with `$clog2`;
  - the layer base offsets (IN·HID, HID);
  - the state enum `nn_sched_state_t`.
- Sub-module `nn_argmax`: tracks best value and index. Inputs: sample-enable, first-flag, value, index. Outputs: `class_idx`.
- Counters:
  - `neuron_cnt` sized to clog2(HID);
  - `input_cnt` sized to clog2(IN);
  - a running `w_addr` register incremented in ACC instead of a multiplier.

## Test plan
- **Reset:** hold `rst` 3 cycles during ACC → every output reads its reset value the cycle after; `start` one cycle later gives normal timing.
- **Small config (IN=4, HID=3, OUT=2):** `start` → `done` rises 34 cycles later. `w_addr` sequence is 0..11 then 12..17. `b_addr` sequence is 0,1,2,3,4. `act_wr_addr` sequence is 0,1,2.
- **Strobe alignment (small config):** for each neuron, exactly 4 (hidden) or 3 (output) `mac_en` cycles start one cycle after `mac_clr`. `bias_en` follows the last `mac_en` by 1 cycle. `act_wr_en` is never asserted in the output layer.
- **Argmax:** `acc_in` in output WB = −5, 7, 7, 2 (OUT=4) → `class_idx` = 1. All values negative, e.g. −9, −3 → `class_idx` = 1.
- **Protocol:** `start` pulsed mid-ACC → ignored and latency unchanged. `start` in DONE → `done` low next cycle and `class_valid` low until the new finish.
- **Defaults:** full run → `done` rises at cycle 51039. Last `w_addr` = 50815. `class_idx` matches the reference model for the bench-driven `acc_in` values.
